// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared widths, state and command encodings
// for the run/debug controller of the 4-bit core.
package cpu_run_ctrl_pkg;

  localparam int CTRL_ADDR_W = 5;
  localparam int CTRL_DATA_W = 8;
  localparam int CTRL_CNT_W  = 8;
  localparam int CTRL_ARG_W  =
    (CTRL_ADDR_W > CTRL_DATA_W) ? CTRL_ADDR_W : CTRL_DATA_W;

  typedef logic [CTRL_ADDR_W-1:0] addr_t;
  typedef logic [CTRL_DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    HALT = 3'd3
  } ctrl_state_t;

  typedef enum logic [2:0] {
    LOAD_ADDR = 3'd0,
    WRITE     = 3'd1,
    SET_BP    = 3'd2,
    CLR_BP    = 3'd3,
    RUN_CMD   = 3'd4,
    STOP      = 3'd5,
    STEP_CMD  = 3'd6,
    RESET_CPU = 3'd7
  } cmd_op_t;

endpackage

// File: rtl/cpu_bp_match.sv
// cpu_bp_match: breakpoint register, comparator and skip flag.
// Ports: set/clr/arg update the bp, arm_skip/retire drive skip_bp, bp_hit out.
module cpu_bp_match
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W = CTRL_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_bp,
  input  logic              clr_bp,
  input  logic [ADDR_W-1:0] bp_arg,
  input  logic              arm_skip,
  input  logic              retire,
  input  logic              run_active,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              bp_hit
);

  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              skip_bp;

  always_ff @(posedge clock) begin
    if (reset) begin
      bp_en   <= 1'b0;
      bp_addr <= '0;
      skip_bp <= 1'b0;
    end else begin
      if (set_bp) begin
        bp_addr <= bp_arg;
        bp_en   <= 1'b1;
      end else if (clr_bp) begin
        bp_en <= 1'b0;
      end
      // resuming from HALT must not re-trip on the parked address
      if (arm_skip)
        skip_bp <= 1'b1;
      else if (retire)
        skip_bp <= 1'b0;
    end
  end

  assign bp_hit = run_active && bp_en &&
                  (cpu_addr == bp_addr) && !skip_bp;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: loads program memory, holds/releases the core, and gates
// it via cpu_en. Ports: cmd_* handshake, cpu_* core control, mem_* writes, status.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W = CTRL_ADDR_W,
  parameter int DATA_W = CTRL_DATA_W,
  parameter int CNT_W  = CTRL_CNT_W,
  localparam int ARG_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ARG_W-1:0]  cmd_arg,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  retired,
  output logic              err
);

  ctrl_state_t       state;
  cmd_op_t           op;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              bp_hit;
  logic              retire;

  assign op        = cmd_op_t'(cmd_op);
  assign cmd_ready = (state != STEP);
  assign accept    = cmd_valid && cmd_ready;
  assign state_o   = state;
  assign retire    = cpu_en && cpu_rst_n;

  // a hit freezes the core in the same cycle so bp_addr never executes
  always_comb begin
    cpu_en = 1'b0;
    unique case (1'b1)
      (state == RUN):  cpu_en = !bp_hit;
      (state == STEP): cpu_en = 1'b1;
      default:         cpu_en = 1'b0;
    endcase
  end

  cpu_bp_match #(
    .ADDR_W (ADDR_W)
  ) u_bp (
    .clock      (clock),
    .reset      (reset),
    .set_bp     (accept && op == SET_BP),
    .clr_bp     (accept && op == CLR_BP),
    .bp_arg     (cmd_arg[ADDR_W-1:0]),
    .arm_skip   (accept && op == RUN_CMD && state == HALT),
    .retire     (retire),
    .run_active (state == RUN),
    .cpu_addr   (cpu_addr),
    .bp_hit     (bp_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HOLD;
      cpu_rst_n <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      retired   <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (retire && retired != '1)
        retired <= retired + 1'b1;

      if (state == STEP || bp_hit)
        state <= HALT;

      // state is never STEP here: cmd_ready is low there
      if (accept) begin
        unique case (op)
          LOAD_ADDR: ptr <= cmd_arg[ADDR_W-1:0];
          WRITE: begin
            if (state == RUN) begin
              err <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_waddr <= ptr;
              mem_wdata <= cmd_arg[DATA_W-1:0];
              ptr       <= ptr + 1'b1;
            end
          end
          SET_BP, CLR_BP: ;
          RUN_CMD: begin
            if (state != RUN) begin
              state     <= RUN;
              cpu_rst_n <= 1'b1;
            end
          end
          STOP: begin
            if (state == RUN)
              state <= HALT;
          end
          STEP_CMD: begin
            if (state == RUN) begin
              err <= 1'b1;
            end else begin
              state     <= STEP;
              cpu_rst_n <= 1'b1;
            end
          end
          RESET_CPU: begin
            state     <= HOLD;
            cpu_rst_n <= 1'b0;
            retired   <= '0;
          end
          default: err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed and random stimulus against a spec-level
// model of the run controller, with a toy core advancing cpu_addr.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cpu_rst_n;
  logic       cpu_en;
  logic [4:0] cpu_addr;
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [2:0] state_o;
  logic [7:0] retired;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  cpu_run_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cpu_rst_n (cpu_rst_n),
    .cpu_en    (cpu_en),
    .cpu_addr  (cpu_addr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .state_o   (state_o),
    .retired   (retired),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // toy core: PC goes to 0 in reset, advances on each enabled cycle
  initial cpu_addr = '0;
  always @(posedge clock) begin
    if (cpu_rst_n === 1'b0)
      cpu_addr <= '0;
    else if (cpu_en === 1'b1)
      cpu_addr <= cpu_addr + 5'd1;
  end

  // reference model
  ctrl_state_t m_phase = HOLD;
  int m_ptr = 0, m_bp = 0, m_retired = 0;
  int m_waddr = 0, m_wdata = 0;
  bit m_bp_on = 0, m_skip = 0, m_err = 0, m_we = 0;

  bit pre_en_obs, pre_en_exp, pre_rdy_obs, pre_rdy_exp;

  function automatic bit model_en();
    bit hit;
    hit = m_bp_on && (int'(cpu_addr) == m_bp) && !m_skip;
    if (m_phase == STEP) return 1'b1;
    if (m_phase == RUN) return !hit;
    return 1'b0;
  endfunction

  task automatic model_edge(input bit rst, input bit acc,
                            input logic [2:0] op, input int a,
                            input bit en);
    ctrl_state_t nxt;
    m_we = 0;
    if (rst) begin
      m_phase = HOLD; m_ptr = 0; m_bp_on = 0; m_bp = 0;
      m_skip = 0; m_retired = 0; m_err = 0;
      return;
    end
    if (en && m_retired < 255) m_retired++;
    if (en) m_skip = 0;
    nxt = m_phase;
    if (m_phase == STEP) nxt = HALT;
    if (m_phase == RUN && !en) nxt = HALT;
    if (acc) begin
      if (op == LOAD_ADDR) m_ptr = a % 32;
      else if (op == WRITE) begin
        if (m_phase == RUN) m_err = 1;
        else begin
          m_we = 1; m_waddr = m_ptr; m_wdata = a;
          m_ptr = (m_ptr + 1) % 32;
        end
      end
      else if (op == SET_BP) begin m_bp = a % 32; m_bp_on = 1; end
      else if (op == CLR_BP) m_bp_on = 0;
      else if (op == RUN_CMD) begin
        if (m_phase != RUN) begin
          if (m_phase == HALT) m_skip = 1;
          nxt = RUN;
        end
      end
      else if (op == STOP) begin
        if (m_phase == RUN) nxt = HALT;
      end
      else if (op == STEP_CMD) begin
        if (m_phase == RUN) m_err = 1;
        else nxt = STEP;
      end
      else begin
        nxt = HOLD; m_retired = 0;
      end
    end
    m_phase = nxt;
  endtask

  // one clock: drive at negedge, run model, return at next negedge
  task automatic step(input bit rst, input bit v,
                      input logic [2:0] op, input logic [7:0] a);
    bit acc;
    reset = rst; cmd_valid = v; cmd_op = op; cmd_arg = a;
    #1;
    pre_en_obs  = cpu_en;
    pre_rdy_obs = cmd_ready;
    pre_en_exp  = model_en();
    pre_rdy_exp = (m_phase != STEP);
    acc = v && pre_rdy_exp;
    model_edge(rst, acc, op, int'(a), pre_en_exp);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, LOAD_ADDR, 8'h00);
  endtask

  task automatic do_reset();
    step(1, 0, LOAD_ADDR, 8'h00);
    step(1, 0, LOAD_ADDR, 8'h00);
    step(0, 0, LOAD_ADDR, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (state_o !== HOLD || cpu_rst_n !== 1'b0 || cpu_en !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: state=%0d rst_n=%b en=%b want 0 0 0",
               state_o, cpu_rst_n, cpu_en);
    end
    n_vec++;
    if (mem_we !== 1'b0 || retired !== 8'd0 || err !== 1'b0 ||
        cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_misc: we=%b ret=%0d err=%b rdy=%b want 0 0 0 1",
               mem_we, retired, err, cmd_ready);
    end
  endtask

  task automatic test_load();
    logic [7:0] d [3];
    d[0] = 8'h31; d[1] = 8'h52; d[2] = 8'hF0;
    step(0, 1, LOAD_ADDR, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, WRITE, d[i]);
      n_vec++;
      if (mem_we !== 1'b1 || mem_waddr !== 5'(i) || mem_wdata !== d[i]) begin
        n_bad++;
        $display("FAIL load_wr%0d: we=%b addr=%0d data=%h want 1 %0d %h",
                 i, mem_we, mem_waddr, mem_wdata, i, d[i]);
      end
    end
    idle(1);
    n_vec++;
    if (mem_we !== 1'b0 || state_o !== HOLD || cpu_rst_n !== 1'b0) begin
      n_bad++;
      $display("FAIL load_after: we=%b state=%0d rst_n=%b want 0 0 0",
               mem_we, state_o, cpu_rst_n);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d [3];
    logic [4:0] w [3];
    d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC;
    w[0] = 5'd31; w[1] = 5'd0;  w[2] = 5'd1;
    step(0, 1, LOAD_ADDR, 8'd31);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, WRITE, d[i]);
      n_vec++;
      if (mem_we !== 1'b1 || mem_waddr !== w[i] || mem_wdata !== d[i]) begin
        n_bad++;
        $display("FAIL wrap_wr%0d: we=%b addr=%0d data=%h want 1 %0d %h",
                 i, mem_we, mem_waddr, mem_wdata, w[i], d[i]);
      end
    end
  endtask

  task automatic test_run_stop();
    step(0, 1, RUN_CMD, 8'd0);
    n_vec++;
    if (state_o !== RUN || cpu_rst_n !== 1'b1 || cpu_en !== 1'b1) begin
      n_bad++;
      $display("FAIL run_start: state=%0d rst_n=%b en=%b want 1 1 1",
               state_o, cpu_rst_n, cpu_en);
    end
    idle(9);
    step(0, 1, STOP, 8'd0);
    n_vec++;
    if (state_o !== HALT || retired !== 8'd10 || cpu_en !== 1'b0) begin
      n_bad++;
      $display("FAIL run_stop: state=%0d ret=%0d en=%b want 3 10 0",
               state_o, retired, cpu_en);
    end
  endtask

  task automatic test_breakpoint();
    bit halted;
    step(0, 1, RESET_CPU, 8'd0);
    idle(1);
    step(0, 1, SET_BP, 8'd3);
    step(0, 1, RUN_CMD, 8'd0);
    halted = 0;
    for (int i = 0; i < 20 && !halted; i++) begin
      n_vec++;
      if (cpu_en !== (cpu_addr != 5'd3)) begin
        n_bad++;
        $display("FAIL bp_gate: addr=%0d en=%b want %b",
                 cpu_addr, cpu_en, cpu_addr != 5'd3);
      end
      idle(1);
      if (state_o === HALT) halted = 1;
    end
    n_vec++;
    if (!halted || retired !== 8'd3 || cpu_addr !== 5'd3 ||
        cpu_en !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_halt: halted=%b ret=%0d addr=%0d en=%b want 1 3 3 0",
               halted, retired, cpu_addr, cpu_en);
    end
    step(0, 1, RUN_CMD, 8'd0);
    idle(1);
    n_vec++;
    if (retired !== 8'd4 || cpu_addr !== 5'd4 || state_o !== RUN) begin
      n_bad++;
      $display("FAIL bp_resume: ret=%0d addr=%0d state=%0d want 4 4 1",
               retired, cpu_addr, state_o);
    end
    step(0, 1, STOP, 8'd0);
  endtask

  task automatic test_step();
    logic [4:0] pc0;
    logic [7:0] r0;
    pc0 = cpu_addr;
    r0  = 8'(m_retired);
    step(0, 1, SET_BP, {3'b000, pc0});
    step(0, 1, STEP_CMD, 8'd0);
    n_vec++;
    if (state_o !== STEP || cmd_ready !== 1'b0 || cpu_en !== 1'b1) begin
      n_bad++;
      $display("FAIL step_on: state=%0d rdy=%b en=%b want 2 0 1",
               state_o, cmd_ready, cpu_en);
    end
    step(0, 1, RUN_CMD, 8'd0);
    n_vec++;
    if (state_o !== HALT || cpu_en !== 1'b0 || retired !== r0 + 8'd1 ||
        cpu_addr !== pc0 + 5'd1) begin
      n_bad++;
      $display("FAIL step_off: state=%0d en=%b ret=%0d addr=%0d want 3 0 %0d %0d",
               state_o, cpu_en, retired, cpu_addr, r0 + 8'd1, pc0 + 5'd1);
    end
    step(0, 1, RUN_CMD, 8'd0);
    step(0, 1, STEP_CMD, 8'd0);
    n_vec++;
    if (err !== 1'b1 || state_o !== RUN) begin
      n_bad++;
      $display("FAIL step_in_run: err=%b state=%0d want 1 1", err, state_o);
    end
    step(0, 1, STOP, 8'd0);
  endtask

  task automatic test_step_hold();
    do_reset();
    step(0, 1, STEP_CMD, 8'd0);
    n_vec++;
    if (state_o !== STEP || cpu_addr !== 5'd0 || cpu_en !== 1'b1 ||
        cpu_rst_n !== 1'b1) begin
      n_bad++;
      $display("FAIL step_hold: state=%0d addr=%0d en=%b rst_n=%b want 2 0 1 1",
               state_o, cpu_addr, cpu_en, cpu_rst_n);
    end
    idle(1);
    n_vec++;
    if (state_o !== HALT || retired !== 8'd1 || cpu_addr !== 5'd1) begin
      n_bad++;
      $display("FAIL step_hold_end: state=%0d ret=%0d addr=%0d want 3 1 1",
               state_o, retired, cpu_addr);
    end
  endtask

  task automatic test_write_run();
    do_reset();
    step(0, 1, LOAD_ADDR, 8'd0);
    step(0, 1, WRITE, 8'h11);
    step(1, 0, LOAD_ADDR, 8'd0);
    n_vec++;
    if (mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_we: we=%b want 0", mem_we);
    end
    step(0, 0, LOAD_ADDR, 8'd0);
    step(0, 1, RUN_CMD, 8'd0);
    idle(2);
    step(0, 1, WRITE, 8'h77);
    n_vec++;
    if (mem_we !== 1'b0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL write_run: we=%b err=%b want 0 1", mem_we, err);
    end
    idle(3);
    step(1, 0, LOAD_ADDR, 8'd0);
    n_vec++;
    if (state_o !== HOLD || retired !== 8'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_run: state=%0d ret=%0d err=%b want 0 0 0",
               state_o, retired, err);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(0, 1, RUN_CMD, 8'd0);
    idle(300);
    n_vec++;
    if (retired !== 8'hFF || state_o !== RUN) begin
      n_bad++;
      $display("FAIL saturate: ret=%0d state=%0d want 255 1",
               retired, state_o);
    end
  endtask

  task automatic test_random();
    bit rst, v;
    logic [2:0] op;
    logic [7:0] a;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 9) < 6);
      op  = ($urandom_range(0, 99) < 3) ? 3'(RESET_CPU)
                                         : 3'($urandom_range(0, 6));
      a   = 8'($urandom_range(0, 255));
      step(rst, v, op, a);
      n_vec++;
      if (pre_en_obs !== pre_en_exp || pre_rdy_obs !== pre_rdy_exp) begin
        n_bad++;
        $display("FAIL rnd_en_rdy@%0d: en=%b rdy=%b want %b %b",
                 i, pre_en_obs, pre_rdy_obs, pre_en_exp, pre_rdy_exp);
      end
      n_vec++;
      if (state_o !== m_phase || cpu_rst_n !== (m_phase != HOLD)) begin
        n_bad++;
        $display("FAIL rnd_state@%0d: state=%0d rst_n=%b want %0d %b",
                 i, state_o, cpu_rst_n, m_phase, m_phase != HOLD);
      end
      n_vec++;
      if (mem_we !== m_we ||
          (m_we && (mem_waddr !== 5'(m_waddr) ||
                    mem_wdata !== 8'(m_wdata)))) begin
        n_bad++;
        $display("FAIL rnd_mem@%0d: we=%b addr=%0d data=%h want %b %0d %h",
                 i, mem_we, mem_waddr, mem_wdata, m_we, m_waddr, m_wdata);
      end
      n_vec++;
      if (retired !== 8'(m_retired) || err !== m_err) begin
        n_bad++;
        $display("FAIL rnd_cnt@%0d: ret=%0d err=%b want %0d %b",
                 i, retired, err, m_retired, m_err);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    @(negedge clock);
    test_reset();
    test_load();
    test_wrap();
    test_run_stop();
    test_breakpoint();
    test_step();
    test_step_hold();
    test_write_run();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
